// File: rtl/HighLevelControl.sv
// Shared control-path types: ALU operation encoding and arbitration limits.
package HighLevelControl;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_AND  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_SLT  = 4'd9
  } aluOperation;

  localparam int ALU_ARB_MAX_REQ = 8;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
    logic illegal;
  } alu_flags_t;

  function automatic logic isLegalAluOp(aluOperation op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLTU, ALU_SLT: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/behavioralAlu.sv
// Combinational integer ALU; result and flags are X for undefined op encodings.
// Carry on SUB is the borrow (A < B unsigned); carry/overflow are 0 for logic, shift and compare ops.
module behavioralAlu
  import HighLevelControl::*;
#(
  parameter int BIT_COUNT = 32
) (
  input  aluOperation            op,
  input  logic [BIT_COUNT-1:0]   a,
  input  logic [BIT_COUNT-1:0]   b,
  output logic [BIT_COUNT-1:0]   result,
  output logic                   zero,
  output logic                   negative,
  output logic                   carry,
  output logic                   overflow
);
  localparam int SH_W = (BIT_COUNT > 1) ? $clog2(BIT_COUNT) : 1;
  localparam int MSB  = BIT_COUNT - 1;

  logic [BIT_COUNT:0]  sum;
  logic [SH_W-1:0]     shamt;

  assign shamt = b[SH_W-1:0];

  always_comb begin
    sum      = '0;
    result   = 'x;
    carry    = 1'bx;
    overflow = 1'bx;
    case (op)
      ALU_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        result   = sum[MSB:0];
        carry    = sum[BIT_COUNT];
        overflow = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        sum      = {1'b0, a} - {1'b0, b};
        result   = sum[MSB:0];
        carry    = sum[BIT_COUNT];
        overflow = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_OR:   begin result = a | b; carry = 1'b0; overflow = 1'b0; end
      ALU_AND:  begin result = a & b; carry = 1'b0; overflow = 1'b0; end
      ALU_XOR:  begin result = a ^ b; carry = 1'b0; overflow = 1'b0; end
      ALU_SLL:  begin result = a << shamt; carry = 1'b0; overflow = 1'b0; end
      ALU_SRL:  begin result = a >> shamt; carry = 1'b0; overflow = 1'b0; end
      ALU_SRA:  begin result = BIT_COUNT'($signed(a) >>> shamt); carry = 1'b0; overflow = 1'b0; end
      ALU_SLTU: begin
        result   = {{(BIT_COUNT-1){1'b0}}, (a < b)};
        carry    = 1'b0;
        overflow = 1'b0;
      end
      ALU_SLT:  begin
        result   = {{(BIT_COUNT-1){1'b0}}, ($signed(a) < $signed(b))};
        carry    = 1'b0;
        overflow = 1'b0;
      end
      default: ;
    endcase
    zero     = ~|result;
    negative = result[MSB];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: scans from Pointer upward, wrapping modulo N; purely combinational.
// Grant is suppressed when Enable is low, GrantIdx still reports the would-be winner.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  Valid,
  input  logic [IW-1:0] Pointer,
  input  logic          Enable,
  output logic [N-1:0]  Grant,
  output logic [IW-1:0] GrantIdx
);
  logic          found;
  logic [IW:0]   idx;

  always_comb begin
    found    = 1'b0;
    GrantIdx = '0;
    Grant    = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      // One extra bit keeps Pointer+k from overflowing before the wrap.
      idx = {1'b0, Pointer} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (!found && Valid[idx[IW-1:0]]) begin
        found    = 1'b1;
        GrantIdx = idx[IW-1:0];
      end
    end
    if (found && Enable) Grant[GrantIdx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU among NUM_REQ requesters with a one-entry registered response.
// Latency 1 cycle; a held unconsumed response blocks all ReqReady, a consumed one swaps in the same edge.
module alu_arbiter
  import HighLevelControl::*;
#(
  parameter int BIT_COUNT = 32,
  parameter int NUM_REQ   = 2,
  parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    ReqValid,
  output logic [NUM_REQ-1:0]    ReqReady,
  input  aluOperation           ReqOp  [NUM_REQ],
  input  logic [BIT_COUNT-1:0]  ReqOpA [NUM_REQ],
  input  logic [BIT_COUNT-1:0]  ReqOpB [NUM_REQ],
  output logic                  RespValid,
  input  logic                  RespReady,
  output logic [ID_W-1:0]       RespId,
  output logic [BIT_COUNT-1:0]  RespResult,
  output logic                  RespZero,
  output logic                  RespNegative,
  output logic                  RespCarry,
  output logic                  RespOverflow,
  output logic                  RespIllegal
);
  logic                 resp_vld_q, resp_vld_d;
  logic [ID_W-1:0]      resp_id_q, resp_id_d;
  logic [BIT_COUNT-1:0] resp_res_q, resp_res_d;
  alu_flags_t           resp_flags_q, resp_flags_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;

  logic                 accept;
  logic                 xfer;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  aluOperation          sel_op;
  logic [BIT_COUNT-1:0] sel_a, sel_b;
  logic [BIT_COUNT-1:0] alu_res;
  logic                 alu_zero, alu_neg, alu_carry, alu_ovf;
  logic                 op_legal;

  assign accept = ~resp_vld_q | RespReady;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr_arbiter (
    .Valid    (ReqValid),
    .Pointer  (ptr_q),
    .Enable   (accept & reset_n),
    .Grant    (grant),
    .GrantIdx (grant_idx)
  );

  assign ReqReady = grant;
  assign xfer     = |grant;

  assign sel_op   = ReqOp[grant_idx];
  assign sel_a    = ReqOpA[grant_idx];
  assign sel_b    = ReqOpB[grant_idx];
  assign op_legal = isLegalAluOp(sel_op);

  behavioralAlu #(.BIT_COUNT(BIT_COUNT)) u_alu (
    .op       (sel_op),
    .a        (sel_a),
    .b        (sel_b),
    .result   (alu_res),
    .zero     (alu_zero),
    .negative (alu_neg),
    .carry    (alu_carry),
    .overflow (alu_ovf)
  );

  always_comb begin
    resp_vld_d   = resp_vld_q;
    resp_id_d    = resp_id_q;
    resp_res_d   = resp_res_q;
    resp_flags_d = resp_flags_q;
    ptr_d        = ptr_q;
    if (xfer) begin
      resp_vld_d = 1'b1;
      resp_id_d  = grant_idx;
      ptr_d      = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      // Illegal ops are squashed here so the ALU's X never gets registered.
      if (op_legal) begin
        resp_res_d   = alu_res;
        resp_flags_d = '{zero: alu_zero, negative: alu_neg, carry: alu_carry,
                         overflow: alu_ovf, illegal: 1'b0};
      end else begin
        resp_res_d   = '0;
        resp_flags_d = '{zero: 1'b0, negative: 1'b0, carry: 1'b0,
                         overflow: 1'b0, illegal: 1'b1};
      end
    end else if (resp_vld_q && RespReady) begin
      resp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_vld_q   <= 1'b0;
      resp_id_q    <= '0;
      resp_res_q   <= '0;
      resp_flags_q <= '0;
      ptr_q        <= '0;
    end else begin
      resp_vld_q   <= resp_vld_d;
      resp_id_q    <= resp_id_d;
      resp_res_q   <= resp_res_d;
      resp_flags_q <= resp_flags_d;
      ptr_q        <= ptr_d;
    end
  end

  assign RespValid    = resp_vld_q;
  assign RespId       = resp_id_q;
  assign RespResult   = resp_res_q;
  assign RespZero     = resp_flags_q.zero;
  assign RespNegative = resp_flags_q.negative;
  assign RespCarry    = resp_flags_q.carry;
  assign RespOverflow = resp_flags_q.overflow;
  assign RespIllegal  = resp_flags_q.illegal;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed table-driven bench for alu_arbiter with two requesters.
module tb_alu_arbiter;
  import HighLevelControl::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  ReqValid;
  logic [1:0]  ReqReady;
  aluOperation ReqOp  [2];
  logic [31:0] ReqOpA [2];
  logic [31:0] ReqOpB [2];
  logic        RespValid;
  logic        RespReady;
  logic [0:0]  RespId;
  logic [31:0] RespResult;
  logic        RespZero, RespNegative, RespCarry, RespOverflow, RespIllegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.BIT_COUNT(32), .NUM_REQ(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqOp        (ReqOp),
    .ReqOpA       (ReqOpA),
    .ReqOpB       (ReqOpB),
    .RespValid    (RespValid),
    .RespReady    (RespReady),
    .RespId       (RespId),
    .RespResult   (RespResult),
    .RespZero     (RespZero),
    .RespNegative (RespNegative),
    .RespCarry    (RespCarry),
    .RespOverflow (RespOverflow),
    .RespIllegal  (RespIllegal)
  );

  // Flags packed as {zero, negative, carry, overflow, illegal}
  typedef struct {
    logic [1:0]  valid;
    aluOperation op0;
    logic [31:0] a0, b0;
    aluOperation op1;
    logic [31:0] a1, b1;
    logic        rr;
    logic [1:0]  exp_rdy;
    logic        exp_vld;
    logic        exp_id;
    logic [31:0] exp_res;
    logic [4:0]  exp_flags;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic [1:0] valid, aluOperation op0, logic [31:0] a0, logic [31:0] b0,
                              aluOperation op1, logic [31:0] a1, logic [31:0] b1, logic rr,
                              logic [1:0] exp_rdy, logic exp_vld, logic exp_id,
                              logic [31:0] exp_res, logic [4:0] exp_flags);
    vec_t v;
    v.valid = valid; v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.op1 = op1; v.a1 = a1; v.b1 = b1; v.rr = rr;
    v.exp_rdy = exp_rdy; v.exp_vld = exp_vld; v.exp_id = exp_id;
    v.exp_res = exp_res; v.exp_flags = exp_flags;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {RespZero, RespNegative, RespCarry, RespOverflow, RespIllegal};
  endfunction

  task automatic check_resp(string tag, logic vld, logic id, logic [31:0] res, logic [4:0] fl);
    check({tag, " RespValid"}, 32'(RespValid), 32'(vld));
    check({tag, " RespId"}, 32'(RespId), 32'(id));
    check({tag, " RespResult"}, RespResult, res);
    check({tag, " flags"}, 32'(flags()), 32'(fl));
    check({tag, " unknown"},
          32'($isunknown({ReqReady, RespValid, RespId, RespResult, flags()})), 32'd0);
  endtask

  task automatic apply(vec_t v, int k);
    ReqValid  = v.valid;
    ReqOp[0]  = v.op0; ReqOpA[0] = v.a0; ReqOpB[0] = v.b0;
    ReqOp[1]  = v.op1; ReqOpA[1] = v.a1; ReqOpB[1] = v.b1;
    RespReady = v.rr;
    #1;
    check($sformatf("v%0d ReqReady", k), 32'(ReqReady), 32'(v.exp_rdy));
    @(posedge clk); #1;
    check_resp($sformatf("v%0d", k), v.exp_vld, v.exp_id, v.exp_res, v.exp_flags);
  endtask

  initial begin
    aluOperation bad_op;
    bad_op = aluOperation'(4'hF);

    reset_n   = 1'b0;
    ReqValid  = 2'b11;
    RespReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ReqOp[i] = ALU_ADD; ReqOpA[i] = '0; ReqOpB[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset ReqReady", 32'(ReqReady), 32'd0);
    check_resp("reset", 1'b0, 1'b0, 32'h0, 5'b00000);
    ReqValid = 2'b00;
    reset_n  = 1'b1;

    // single ADD overflow; then req1 SRA/SLTU back-to-back
    vq.push_back(mk(2'b01, ALU_ADD, 32'h7FFFFFFF, 32'h1, ALU_ADD, 32'h0, 32'h0, 1'b1,
                    2'b01, 1'b1, 1'b0, 32'h80000000, 5'b01010));
    vq.push_back(mk(2'b10, ALU_ADD, 32'h0, 32'h0, ALU_SRA, 32'h80000000, 32'd4, 1'b1,
                    2'b10, 1'b1, 1'b1, 32'hF8000000, 5'b01000));
    vq.push_back(mk(2'b10, ALU_ADD, 32'h0, 32'h0, ALU_SLTU, 32'hFFFFFFFF, 32'h1, 1'b1,
                    2'b10, 1'b1, 1'b1, 32'h0, 5'b10000));
    // round robin 0,1,0,1
    for (int i = 0; i < 2; i++) begin
      vq.push_back(mk(2'b11, ALU_SUB, 32'd5, 32'd5, ALU_SLT, 32'hFFFFFFFF, 32'h1, 1'b1,
                      2'b01, 1'b1, 1'b0, 32'h0, 5'b10000));
      vq.push_back(mk(2'b11, ALU_SUB, 32'd5, 32'd5, ALU_SLT, 32'hFFFFFFFF, 32'h1, 1'b1,
                      2'b10, 1'b1, 1'b1, 32'h1, 5'b00000));
    end
    // backpressure for three cycles, then swap on release
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(2'b11, ALU_SUB, 32'd5, 32'd5, ALU_SLT, 32'hFFFFFFFF, 32'h1, 1'b0,
                      2'b00, 1'b1, 1'b1, 32'h1, 5'b00000));
    vq.push_back(mk(2'b11, ALU_SUB, 32'd5, 32'd5, ALU_SLT, 32'hFFFFFFFF, 32'h1, 1'b1,
                    2'b01, 1'b1, 1'b0, 32'h0, 5'b10000));
    // illegal op, then drain with fields held
    vq.push_back(mk(2'b01, bad_op, 32'h12345678, 32'h11111111, ALU_SLT, 32'h0, 32'h0, 1'b1,
                    2'b01, 1'b1, 1'b0, 32'h0, 5'b00001));
    vq.push_back(mk(2'b00, bad_op, 32'h12345678, 32'h11111111, ALU_SLT, 32'h0, 32'h0, 1'b1,
                    2'b00, 1'b0, 1'b0, 32'h0, 5'b00001));

    @(posedge clk); #1;
    foreach (vq[k]) apply(vq[k], k);

    // Pointer is 1 here; req0 wins alone and leaves the pointer at 1 with a held response.
    apply(mk(2'b01, ALU_ADD, 32'd2, 32'd3, ALU_ADD, 32'd2, 32'd3, 1'b0,
             2'b01, 1'b1, 1'b0, 32'd5, 5'b00000), 100);
    ReqValid = 2'b11;
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset ReqReady", 32'(ReqReady), 32'd0);
    check_resp("async reset", 1'b0, 1'b0, 32'h0, 5'b00000);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post-reset pointer grant", 32'(ReqReady), 32'b01);
    ReqValid = 2'b10;
    #1;
    check("post-reset req1 ready", 32'(ReqReady), 32'b10);
    @(posedge clk); #1;
    check_resp("post-reset req1", 1'b1, 1'b1, 32'd5, 5'b00000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
